// File: rtl/uart_pkg.sv
// Shared defaults and sequencer state type for the UART transmit path.
package uart_pkg;

  localparam int unsigned UART_DATA_W  = 8;
  localparam int unsigned UART_DEPTH   = 16;
  localparam int unsigned UART_BUSY_TO = 64;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FIRE,
    WAIT_BUSY,
    WAIT_DONE
  } txfifo_state_e;

endpackage

// File: rtl/sync_fifo_mem.sv
// Register-array FIFO storage: clocked write port, combinational read port.
module sync_fifo_mem
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W = UART_DATA_W,
  parameter int unsigned DEPTH  = UART_DEPTH,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data_c
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data_c = r_mem[i_rd_addr];

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// Transmit FIFO and sequencer feeding the UART transceiver one byte per frame,
// paced by tx_busy, with sticky overflow and busy-timeout flags.
module uart_tx_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned  DATA_W  = UART_DATA_W,
  parameter int unsigned  DEPTH   = UART_DEPTH,
  parameter int unsigned  BUSY_TO = UART_BUSY_TO,
  localparam int unsigned ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_err,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              tx_err,
  output logic [DATA_W-1:0] TxData,
  output logic              transmit,
  input  logic              tx_busy
);

  localparam int unsigned      CNT_W    = $clog2(BUSY_TO + 1);
  localparam logic [ADDR_W:0]  FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(BUSY_TO - 1);

  txfifo_state_e     r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDR_W:0]   r_count, w_count_nxt;
  logic              r_full, r_empty, r_overflow, r_tx_err, r_transmit;
  logic [DATA_W-1:0] r_tx_data, w_rd_data;
  logic [CNT_W-1:0]  r_to_cnt, w_to_cnt_nxt;
  logic              w_push, w_drop, w_pop, w_to_err;

  sync_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk         (clk),
    .i_wr_en     (w_push),
    .i_wr_addr   (r_wr_ptr),
    .i_wr_data   (wr_data),
    .i_rd_addr   (r_rd_ptr),
    .o_rd_data_c (w_rd_data)
  );

  // full is the registered flag, so a write is refused even if a pop lands in the same cycle
  assign w_push      = wr_en && !r_full;
  assign w_drop      = wr_en && r_full;
  assign w_pop       = (r_state == LOAD);
  assign w_count_nxt = r_count + (ADDR_W+1)'(w_push) - (ADDR_W+1)'(w_pop);

  // Sequencer next state; a byte whose busy never rises is dropped, not retried
  always_comb begin
    w_state_nxt  = r_state;
    w_to_cnt_nxt = r_to_cnt;
    w_to_err     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!r_empty && !tx_busy) w_state_nxt = LOAD;
      end
      LOAD: w_state_nxt = FIRE;
      FIRE: begin
        w_to_cnt_nxt = '0;
        w_state_nxt  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          w_state_nxt = WAIT_DONE;
        end else begin
          w_to_cnt_nxt = r_to_cnt + CNT_W'(1);
          if (w_to_cnt_nxt == TO_LAST) begin
            w_to_err    = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_to_cnt   <= '0;
      r_transmit <= 1'b0;
      r_tx_data  <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
      r_tx_err   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_to_cnt   <= w_to_cnt_nxt;
      r_transmit <= (w_state_nxt == FIRE);
      if (w_pop) begin
        r_tx_data <= w_rd_data;
        r_rd_ptr  <= r_rd_ptr + ADDR_W'(1);
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      r_count    <= w_count_nxt;
      r_full     <= (w_count_nxt == FULL_CNT);
      r_empty    <= (w_count_nxt == '0);
      // a new event outranks a coincident clear
      r_overflow <= w_drop | (r_overflow & ~clr_err);
      r_tx_err   <= w_to_err | (r_tx_err & ~clr_err);
    end
  end

  assign full     = r_full;
  assign empty    = r_empty;
  assign count    = r_count;
  assign overflow = r_overflow;
  assign tx_err   = r_tx_err;
  assign TxData   = r_tx_data;
  assign transmit = r_transmit;

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Directed bench for uart_tx_fifo_ctrl with a simple transceiver busy model.
module tb_uart_tx_fifo_ctrl;

  localparam int unsigned DEPTH   = 16;
  localparam int unsigned BUSY_TO = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       clr_err;
  logic       full, empty, overflow, tx_err, transmit;
  logic [4:0] count;
  logic [7:0] TxData;
  logic       tx_busy;

  logic man_busy = 1'b0;
  logic model_en = 1'b0;
  logic m_busy;
  int   m_ph, m_cnt;
  int   rise_dly = 2;
  int   frame_len = 10;

  int n_chk = 0;
  int n_bad = 0;
  int v_busy = 0, v_width = 0, v_stab = 0, v_cnt = 0;
  logic [7:0] sent_q[$];

  assign tx_busy = model_en ? m_busy : man_busy;

  uart_tx_fifo_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .clr_err  (clr_err),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .tx_err   (tx_err),
    .TxData   (TxData),
    .transmit (transmit),
    .tx_busy  (tx_busy)
  );

  initial forever #5 clk = ~clk;

  // Transceiver: busy rises rise_dly cycles after a pulse and stays up frame_len cycles
  initial begin
    m_ph = 0; m_cnt = 0; m_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!model_en || reset) begin
        m_ph = 0; m_cnt = 0; m_busy = 1'b0;
      end else begin
        case (m_ph)
          0: if (transmit) begin m_ph = 1; m_cnt = rise_dly; end
          1: begin
            m_cnt--;
            if (m_cnt == 0) begin m_busy = 1'b1; m_ph = 2; m_cnt = frame_len; end
          end
          2: begin
            m_cnt--;
            if (m_cnt == 0) begin m_busy = 1'b0; m_ph = 0; end
          end
          default: m_ph = 0;
        endcase
      end
    end
  end

  // Protocol watch: pulse width, pulse under busy, TxData stability, occupancy bound
  initial begin
    logic       prev_tx;
    logic [7:0] frame_data;
    prev_tx = 1'b0; frame_data = 8'h00;
    forever begin
      @(posedge clk); #2;
      if (reset) begin
        prev_tx = 1'b0;
      end else begin
        if (transmit && tx_busy) v_busy++;
        if (transmit && prev_tx) v_width++;
        if (transmit) begin
          frame_data = TxData;
          sent_q.push_back(TxData);
        end else if (tx_busy && TxData !== frame_data) begin
          v_stab++;
        end
        if (count > 5'(DEPTH)) v_cnt++;
        prev_tx = transmit;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, required finish before it");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic stepn(input int n);
    repeat (n) step();
  endtask

  task automatic write_byte(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  // Wait until FIFO, sequencer and transceiver have all been quiet for 4 cycles
  task automatic wait_drain(input string tag);
    int quiet = 0;
    int budget = 4000;
    while (quiet < 4 && budget > 0) begin
      step();
      budget--;
      if (empty && !transmit && !tx_busy && m_ph == 0) quiet++;
      else quiet = 0;
    end
    chk({tag, "_drain"}, 32'(quiet), 32'd4);
  endtask

  initial begin
    int k;
    int idx;
    int budget;
    reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; clr_err = 1'b0;
    stepn(3);
    chk("rst_count",    32'(count),    32'd0);
    chk("rst_empty",    32'(empty),    32'd1);
    chk("rst_full",     32'(full),     32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_tx_err",   32'(tx_err),   32'd0);
    chk("rst_txdata",   32'(TxData),   32'd0);
    chk("rst_transmit", 32'(transmit), 32'd0);
    reset = 1'b0;
    step();

    // single byte, latency write -> pulse is 3 cycles
    model_en = 1'b1; rise_dly = 2; frame_len = 10;
    write_byte(8'hA5);
    chk("t1_empty_c1", 32'(empty), 32'd0);
    chk("t1_count_c1", 32'(count), 32'd1);
    step();
    chk("t1_nopulse_c2", 32'(transmit), 32'd0);
    step();
    chk("t1_pulse_c3",  32'(transmit), 32'd1);
    chk("t1_txdata_c3", 32'(TxData),   32'h0A5);
    chk("t1_count_c3",  32'(count),    32'd0);
    chk("t1_empty_c3",  32'(empty),    32'd1);
    step();
    chk("t1_pulse_end", 32'(transmit), 32'd0);
    wait_drain("t1");
    chk("t1_sent", 32'(sent_q.size()), 32'd1);
    sent_q.delete();

    // burst of 17 while busy: 16 stored, last dropped
    model_en = 1'b0; man_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      step();
    end
    chk("t2_full16",   32'(full),     32'd1);
    chk("t2_count16",  32'(count),    32'd16);
    chk("t2_ovf_pre",  32'(overflow), 32'd0);
    wr_data = 8'h10;
    step();
    wr_en = 1'b0;
    chk("t2_ovf",       32'(overflow), 32'd1);
    chk("t2_count_drop", 32'(count),   32'd16);
    wr_en = 1'b1; wr_data = 8'hEE; clr_err = 1'b1;
    step();
    wr_en = 1'b0; clr_err = 1'b0;
    chk("t2_set_wins", 32'(overflow), 32'd1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("t2_clr",        32'(overflow),      32'd0);
    chk("t2_none_busy",  32'(sent_q.size()), 32'd0);
    frame_len = 5; model_en = 1'b1; man_busy = 1'b0;
    wait_drain("t2");
    chk("t2_sent", 32'(sent_q.size()), 32'd16);
    for (int i = 0; i < 16 && i < sent_q.size(); i++)
      chk("t2_order", 32'(sent_q[i]), 32'(i));
    sent_q.delete();

    // backpressure: long frames, one pulse per frame
    frame_len = 100; rise_dly = 2;
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    wait_drain("t3");
    chk("t3_sent", 32'(sent_q.size()), 32'd3);
    if (sent_q.size() == 3) begin
      chk("t3_b0", 32'(sent_q[0]), 32'h11);
      chk("t3_b1", 32'(sent_q[1]), 32'h22);
      chk("t3_b2", 32'(sent_q[2]), 32'h33);
    end
    sent_q.delete();

    // busy never rises: tx_err exactly BUSY_TO cycles after the pulse
    model_en = 1'b0; man_busy = 1'b0;
    write_byte(8'h3C);
    k = 0;
    while (!transmit && k < 10) begin step(); k++; end
    chk("t4_latency", 32'(k),      32'd2);
    chk("t4_txdata",  32'(TxData), 32'h3C);
    stepn(BUSY_TO - 1);
    chk("t4_err_early", 32'(tx_err), 32'd0);
    step();
    chk("t4_err",   32'(tx_err), 32'd1);
    chk("t4_empty", 32'(empty),  32'd1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("t4_clr", 32'(tx_err), 32'd0);
    write_byte(8'h5A);
    stepn(2);
    chk("t4_idle_pulse",  32'(transmit), 32'd1);
    chk("t4_idle_txdata", 32'(TxData),   32'h5A);
    step();
    man_busy = 1'b1;
    stepn(3);
    man_busy = 1'b0;
    stepn(3);
    chk("t4_no_err",   32'(tx_err),        32'd0);
    chk("t4_no_retry", 32'(sent_q.size()), 32'd2);
    sent_q.delete();

    // stream 40 bytes honouring full: pointers wrap, order kept
    model_en = 1'b1; rise_dly = 1; frame_len = 3;
    idx = 0; budget = 2000;
    while (idx < 40 && budget > 0) begin
      if (!full) begin
        wr_en = 1'b1; wr_data = 8'(32'h80 + idx); idx++;
      end else begin
        wr_en = 1'b0;
      end
      step();
      budget--;
    end
    wr_en = 1'b0;
    wait_drain("t5");
    chk("t5_ovf",  32'(overflow),      32'd0);
    chk("t5_sent", 32'(sent_q.size()), 32'd40);
    for (int i = 0; i < 40 && i < sent_q.size(); i++)
      chk("t5_order", 32'(sent_q[i]), 32'h80 + 32'(i));
    sent_q.delete();

    // reset during a frame with 5 bytes still queued
    model_en = 1'b0; man_busy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = 8'(32'hC1 + i);
      step();
    end
    wr_en = 1'b0; man_busy = 1'b1;
    stepn(3);
    chk("t6_count",    32'(count),         32'd5);
    chk("t6_sent_one", 32'(sent_q.size()), 32'd1);
    chk("t6_txdata",   32'(TxData),        32'hC1);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_transmit", 32'(transmit), 32'd0);
    chk("t6_rst_count",    32'(count),    32'd0);
    chk("t6_rst_empty",    32'(empty),    32'd1);
    chk("t6_rst_txdata",   32'(TxData),   32'd0);
    man_busy = 1'b0;
    stepn(2);
    reset = 1'b0;
    stepn(10);
    chk("t6_no_pulse", 32'(sent_q.size()), 32'd1);
    chk("t6_empty",    32'(empty),         32'd1);
    write_byte(8'hE7);
    stepn(2);
    chk("t6_new_pulse",  32'(transmit), 32'd1);
    chk("t6_new_txdata", 32'(TxData),   32'hE7);
    stepn(3);

    chk("mon_pulse_busy",  32'(v_busy),  32'd0);
    chk("mon_pulse_width", 32'(v_width), 32'd0);
    chk("mon_txdata_hold", 32'(v_stab),  32'd0);
    chk("mon_count_max",   32'(v_cnt),   32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
